// File: rtl/imem_issue_buf.sv
// imem_issue_buf: in-order issue buffer between the memory issue queue and
// the load/store unit. Accepts up to two ops per cycle (lane 0 older) and
// presents one entry per cycle to the LSU from a circular buffer.
// Optional feature: define IMEM_ISSUE_BYPASS_EN to let lane 0 go straight
// to the LSU in the same cycle when the buffer is empty.

package imem_issue_buf_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        is_store;
    } issue_entry_t;

    typedef struct packed {
        issue_entry_t entry;
    } read_resp_t;

endpackage

module imem_issue_buf
    import imem_issue_buf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  read_resp_t [1:0]       read,
    output logic                   stall,
    output logic                   mem_valid,
    output issue_entry_t           mem_entry,
    input  logic                   mem_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    issue_entry_t  buf_q [DEPTH];

    logic          acc0, acc1;
    logic          byp, byp_take;
    logic          buf_valid, pop;
    logic          wr0, wr1;
    logic [AW-1:0] widx0, widx1;

    // Fewer than two free slots means a two-lane push could overflow, so stall.
    assign stall = flush | (count_q > CW'(DEPTH - 2));

    assign acc0 = ~stall & read[0].entry.valid;
    assign acc1 = acc0 & read[1].entry.valid;

`ifdef IMEM_ISSUE_BYPASS_EN
    // Empty buffer: lane 0 is shown to the LSU in the cycle it arrives.
    assign byp      = (count_q == '0) & acc0;
    assign byp_take = byp & mem_ready;
`else
    assign byp      = 1'b0;
    assign byp_take = 1'b0;
`endif

    assign buf_valid = (count_q != '0) & ~flush;
    assign pop       = buf_valid & mem_ready;
    assign mem_valid = buf_valid | byp;
    assign mem_entry = byp ? read[0].entry : buf_q[head_q[AW-1:0]];

    // A bypassed lane 0 that the LSU takes immediately never occupies a slot.
    assign wr0   = acc0 & ~byp_take;
    assign wr1   = acc1;
    assign widx0 = tail_q[AW-1:0];
    assign widx1 = widx0 + AW'(wr0);

    // Next-state for pointers and occupancy; flush empties the buffer.
    always_comb begin
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(wr0) + PW'(wr1);
        count_d = count_q + CW'(wr0) + CW'(wr1) - CW'(pop);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer/count registers; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage, written in lane order at the tail; contents need no reset.
    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            if (wr0) buf_q[widx0] <= read[0].entry;
            if (wr1) buf_q[widx1] <= read[1].entry;
        end
    end

    // Pointer distance (with the extra MSB) must always equal the occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ((tail_q - head_q) == PW'(count_q));
        end
    end

endmodule

// File: tb/tb_imem_issue_buf.sv
// Bench for imem_issue_buf: directed scenarios plus random traffic, checked
// by a scoreboard queue that models the buffer as an ordered list of entries.
module tb_imem_issue_buf;
    import imem_issue_buf_pkg::*;

    localparam int DEPTH = 4;
`ifdef IMEM_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset, flush, mem_ready;
    read_resp_t [1:0] rd_in;
    logic             stall, mem_valid;
    issue_entry_t     mem_entry;

    imem_issue_buf #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush), .read(rd_in),
        .stall(stall), .mem_valid(mem_valid), .mem_entry(mem_entry),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int           total = 0;
    int           bad   = 0;
    issue_entry_t exp_q[$];
    int           cur_occ;
    bit           cur_flush, cur_acc0, cur_stall, mon_en;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic issue_entry_t mk(input bit v);
        issue_entry_t e;
        e.valid    = v;
        e.pc       = $urandom;
        e.rd       = 5'($urandom);
        e.is_store = 1'($urandom);
        return e;
    endfunction

    // One cycle of stimulus; the model decides acceptance from occupancy alone.
    task automatic step(input bit v0, input bit v1, input bit fl, input bit rdy);
        int occ;
        bit st;
        occ           = exp_q.size();
        rd_in[0].entry = mk(v0);
        rd_in[1].entry = mk(v1);
        flush         = fl;
        mem_ready     = rdy;
        st            = fl || ((DEPTH - occ) < 2);
        cur_occ       = occ;
        cur_flush     = fl;
        cur_stall     = st;
        cur_acc0      = !st && v0;
        if (fl) exp_q.delete();
        else if (!st && v0) begin
            exp_q.push_back(rd_in[0].entry);
            if (v1) exp_q.push_back(rd_in[1].entry);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (DEPTH + 2) step(0, 0, 0, 1);
    endtask

    // Monitor: checks outputs mid-cycle and retires entries on handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_mv;
            exp_mv = !cur_flush && (cur_occ != 0 || (BYP && cur_acc0));
            chk("stall", 64'(stall), 64'(cur_stall));
            chk("count", 64'(dut.count_q), 64'(cur_occ));
            chk("mem_valid", 64'(mem_valid), 64'(exp_mv));
            if (mem_valid && exp_mv && exp_q.size() > 0) begin
                chk("mem_entry", 64'(mem_entry), 64'(exp_q[0]));
                if (mem_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        mon_en    = 1'b0;
        reset     = 1'b1;
        flush     = 1'b0;
        mem_ready = 1'b0;
        rd_in     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 64'(dut.count_q), 64'd0);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // first cycle after reset: idle, no stall, nothing valid
        step(0, 0, 0, 1);

        // two lanes, ready high: issued in two consecutive cycles, lane 0 first
        step(1, 1, 0, 1);
        drain();

        // ready low, two lanes per cycle: 2, then 4, then stalled
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        drain();

        // count 3 with a pop and lanes valid -> stalled, count 2; then 2 in 1 out -> 3
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 1);
        step(1, 1, 0, 1);
        step(0, 0, 0, 0);
        drain();

        // ten entries across pointer wrap with ready toggling
        for (int i = 0; i < 10; i++) step(1, 0, 0, (i % 2) == 0);
        drain();

        // flush at count 3 with both lanes valid
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 1, 1);
        step(0, 0, 0, 1);

        // empty buffer, single lane, ready high (bypass vs one-cycle latency)
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        drain();

        // reset wins over flush/push/pop in the same cycle
        step(1, 1, 0, 0);
        mon_en         = 1'b0;
        reset          = 1'b1;
        flush          = 1'b1;
        mem_ready      = 1'b1;
        rd_in[0].entry = mk(1);
        rd_in[1].entry = mk(1);
        @(posedge clk);
        #1;
        rd_in = '0;
        flush = 1'b0;
        chk("rst_prio_count", 64'(dut.count_q), 64'd0);
        chk("rst_prio_valid", 64'(mem_valid), 64'd0);
        exp_q.delete();
        reset  = 1'b0;
        step(0, 0, 0, 1);
        mon_en = 1'b1;
        step(0, 0, 0, 1);

        // random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);
        drain();

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_issue_buf.md
IMEM_ISSUE_BUF -- requirements
Module: imem_issue_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, buffer entries; power of two, minimum 2.
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port flush  input  1  pipeline flush; discards all buffered entries.
REQ-005 SHALL have port read  input  2 x read_resp_t  in-order memory ops from the memory issue queue; lane 0 is older.
REQ-006 SHALL have port stall  output  1  backpressure to the memory issue queue; high means no entries are accepted this cycle.
REQ-007 SHALL have port mem_valid  output  1  an entry is presented to the load/store unit.
REQ-008 SHALL have port mem_entry  output  issue entry type (read_resp_t.entry)  the presented entry.
REQ-009 SHALL have port mem_ready  input  1  load/store unit accepts mem_entry this cycle.

Function
REQ-010 SHALL hold entries in a circular buffer with head/tail pointers of log2(DEPTH)+1 bits and an occupancy count of 0..DEPTH.
REQ-011 SHALL drive stall = flush OR (DEPTH - count < 2), combinationally from registered count and flush.
REQ-012 SHALL, when stall is low, push read[0].entry if read[0].entry.valid, then push read[1].entry if both lanes are valid, in lane order.
REQ-013 SHALL ignore read[1] when read[0].entry.valid is low.
REQ-014 SHALL ignore both lanes when stall is high, whatever their valid bits.
REQ-015 SHALL drive mem_valid = (count != 0) AND NOT flush, and mem_entry = buffer[head].
REQ-016 SHALL pop head when mem_valid AND mem_ready are both high.
REQ-017 SHALL update count_next = count + pushes - pops (pushes 0..2, pops 0..1) when push and pop occur in the same cycle.
REQ-018 SHALL wrap the pointers modulo DEPTH; the extra MSB distinguishes full from empty.
REQ-019 SHALL hold mem_entry stable while mem_valid is high and mem_ready is low, until pop or flush.
REQ-020 SHALL issue entries strictly in arrival order, at most one per cycle.
REQ-021 SHALL, on flush, discard any push or pop in that cycle and set count, head and tail to 0 on the next edge.
REQ-022 SHALL be 1-cycle latency, read accept to mem_valid, without the bypass feature.

Reset
REQ-023 SHALL set count, head and tail to 0 on reset; buffer contents are don't-care.
REQ-024 SHALL hold mem_valid at 0 and stall at 0 (flush low) during the first cycle after reset.
REQ-025 SHALL give reset priority over flush, push and pop in the same cycle.

Configuration
REQ-026 SHALL, when IMEM_ISSUE_BYPASS_EN is defined and count == 0 with read[0] accepted and flush low, drive mem_valid high and mem_entry = read[0].entry in the same cycle (0-cycle latency).
REQ-027 SHALL, in the bypass case with mem_ready high, not write read[0] into the buffer (count increases only by lane-1 pushes); with mem_ready low, buffer it normally.
REQ-028 SHALL, without IMEM_ISSUE_BYPASS_EN, have no combinational path from read to mem_valid/mem_entry.

Verification
REQ-029 SHALL cover: DEPTH=4, reset, two valid lanes for one cycle, mem_ready=1 -> mem_valid for 2 consecutive cycles, lane 0 first, count returns to 0.
REQ-030 SHALL cover: mem_ready=0, two lanes per cycle -> count=2 after 1 cycle, stall=1 when count=3 or 4, no further accepts; mem_entry unchanged throughout.
REQ-031 SHALL cover: count=3, mem_ready=1 with a pop, read lanes valid -> stall=1 that cycle, count=2 next; then 2 pushes + 1 pop -> count=3.
REQ-032 SHALL cover: 10 entries streamed through with ready toggling 1,0,1,0 -> output order matches input order across pointer wrap, no loss or duplication.
REQ-033 SHALL cover: flush asserted with count=3 and both lanes valid -> mem_valid=0 and stall=1 that cycle, count=0 next cycle, lanes not captured.
REQ-034 SHALL cover: with IMEM_ISSUE_BYPASS_EN, empty buffer, single lane valid, mem_ready=1 -> mem_valid=1 same cycle with that entry and count stays 0; without the macro, mem_valid=1 one cycle later.
